// File: rtl/sram_arbiter_2p_pkg.sv
// Shared encodings and defaults for the two-port SRAM arbiter.
// Holds FSM states, port identifiers and default bus widths.
package sram_arbiter_2p_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  localparam int DEF_ADDR_WIDTH    = 20;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ACCESS_CYCLES = 2;

  function automatic port_t other_port(input port_t p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/sram_arbiter_2p_rr_arbiter_2.sv
// Combinational two-way round-robin pick: a sole requester wins,
// a tie goes to the port that did not win last time.
module rr_arbiter_2
  import sram_arbiter_2p_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant_vld,
  output logic grant
);

  always_comb begin
    grant_vld = req_a | req_b;
    grant     = PORT_A;
    if (req_a && req_b) begin
      grant = other_port(port_t'(last_grant));
    end else if (req_b) begin
      grant = PORT_B;
    end
  end

endmodule

// File: rtl/sram_arbiter_2p.sv
// Round-robin share of one SRAM controller between ports A and B; each command is
// held ACCESS_CYCLES cycles, then read data returns to its owner. All outputs registered.
module sram_arbiter_2p
  import sram_arbiter_2p_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_a_req,
  input  logic                  i_a_write,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic [DATA_WIDTH-1:0] i_a_wdata,
  output logic                  o_a_ack,
  output logic [DATA_WIDTH-1:0] o_a_rdata,
  output logic                  o_a_rvalid,
  input  logic                  i_b_req,
  input  logic                  i_b_write,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  input  logic [DATA_WIDTH-1:0] i_b_wdata,
  output logic                  o_b_ack,
  output logic [DATA_WIDTH-1:0] o_b_rdata,
  output logic                  o_b_rvalid,
  output logic                  o_m_write,
  output logic [ADDR_WIDTH-1:0] o_m_addr,
  output logic [DATA_WIDTH-1:0] o_m_data,
  input  logic [DATA_WIDTH-1:0] i_m_data,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  port_t                 last_grant_q, last_grant_d;
  logic                  m_write_q, m_write_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  a_ack_q, a_ack_d;
  logic                  b_ack_q, b_ack_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic                  busy_q, busy_d;

  logic grant_vld;
  logic grant;

  rr_arbiter_2 u_rr (
    .req_a      (i_a_req),
    .req_b      (i_b_req),
    .last_grant (last_grant_q),
    .grant_vld  (grant_vld),
    .grant      (grant)
  );

  // last_grant doubles as the owner of the access in flight.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    m_write_d    = m_write_q;
    m_addr_d     = m_addr_q;
    m_data_d     = m_data_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    busy_d       = busy_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    a_rvalid_d   = 1'b0;
    b_rvalid_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d      = ST_ACCESS;
          cnt_d        = CNT_W'(ACCESS_CYCLES - 1);
          last_grant_d = port_t'(grant);
          busy_d       = 1'b1;
          if (grant == PORT_A) begin
            m_write_d = i_a_write;
            m_addr_d  = i_a_addr;
            m_data_d  = i_a_wdata;
            a_ack_d   = 1'b1;
          end else begin
            m_write_d = i_b_write;
            m_addr_d  = i_b_addr;
            m_data_d  = i_b_wdata;
            b_ack_d   = 1'b1;
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d   = ST_IDLE;
          m_write_d = 1'b0;
          busy_d    = 1'b0;
          // A low write strobe during the access marks it as a read.
          if (!m_write_q) begin
            if (last_grant_q == PORT_A) begin
              a_rdata_d  = i_m_data;
              a_rvalid_d = 1'b1;
            end else begin
              b_rdata_d  = i_m_data;
              b_rvalid_d = 1'b1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= PORT_B;
      m_write_q    <= 1'b0;
      m_addr_q     <= '0;
      m_data_q     <= '0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      m_write_q    <= m_write_d;
      m_addr_q     <= m_addr_d;
      m_data_q     <= m_data_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      busy_q       <= busy_d;
    end
  end

  assign o_a_ack    = a_ack_q;
  assign o_b_ack    = b_ack_q;
  assign o_a_rdata  = a_rdata_q;
  assign o_b_rdata  = b_rdata_q;
  assign o_a_rvalid = a_rvalid_q;
  assign o_b_rvalid = b_rvalid_q;
  assign o_m_write  = m_write_q;
  assign o_m_addr   = m_addr_q;
  assign o_m_data   = m_data_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Directed bench for sram_arbiter_2p with a behavioural 1Mx8 SRAM behind it.
module tb_sram_arbiter_2p;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_write, b_req, b_write;
  logic [19:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_ack, a_rvalid, b_ack, b_rvalid;
  logic [7:0]  a_rdata, b_rdata;
  logic        m_write;
  logic [19:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;
  logic        busy;

  logic        load_en;
  logic [19:0] load_addr;
  logic [7:0]  load_dat;
  logic [7:0]  mem [0:1048575];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_arbiter_2p dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_a_req    (a_req),
    .i_a_write  (a_write),
    .i_a_addr   (a_addr),
    .i_a_wdata  (a_wdata),
    .o_a_ack    (a_ack),
    .o_a_rdata  (a_rdata),
    .o_a_rvalid (a_rvalid),
    .i_b_req    (b_req),
    .i_b_write  (b_write),
    .i_b_addr   (b_addr),
    .i_b_wdata  (b_wdata),
    .o_b_ack    (b_ack),
    .o_b_rdata  (b_rdata),
    .o_b_rvalid (b_rvalid),
    .o_m_write  (m_write),
    .o_m_addr   (m_addr),
    .o_m_data   (m_wdata),
    .i_m_data   (m_rdata),
    .o_busy     (busy)
  );

  // Behavioural SRAM: synchronous write, registered read, plus a preload port.
  always @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_dat;
    else if (m_write) mem[m_addr] <= m_wdata;
    m_rdata <= mem[m_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [19:0] addr, input logic [7:0] dat);
    load_addr = addr;
    load_dat  = dat;
    load_en   = 1'b1;
    step();
    load_en   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_req = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
    load_en = 1'b0; load_addr = '0; load_dat = '0;
    #1;
    preload(20'h00011, 8'h3C);
    preload(20'h00022, 8'hC3);

    // 1: reset held with both requests high
    a_req = 1'b1; b_req = 1'b1;
    a_addr = 20'h00011; b_addr = 20'h00022;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_a_ack", 32'(a_ack), 32'd0);
      check("rst_b_ack", 32'(b_ack), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_m_write", 32'(m_write), 32'd0);
    end
    check("rst_m_addr", 32'(m_addr), 32'd0);
    check("rst_m_data", 32'(m_wdata), 32'd0);
    check("rst_a_rdata", 32'(a_rdata), 32'd0);
    check("rst_b_rdata", 32'(b_rdata), 32'd0);
    check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    reset = 1'b0; a_req = 1'b0; b_req = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // 2: A write 0x12345 <= 0xA5
    a_req = 1'b1; a_write = 1'b1; a_addr = 20'h12345; a_wdata = 8'hA5;
    step();
    check("wr_a_ack", 32'(a_ack), 32'd1);
    check("wr_m_write0", 32'(m_write), 32'd1);
    check("wr_m_addr", 32'(m_addr), 32'h12345);
    check("wr_m_data", 32'(m_wdata), 32'hA5);
    check("wr_busy0", 32'(busy), 32'd1);
    a_req = 1'b0;
    step();
    check("wr_a_ack_once", 32'(a_ack), 32'd0);
    check("wr_m_write1", 32'(m_write), 32'd1);
    check("wr_busy1", 32'(busy), 32'd1);
    step();
    check("wr_m_write_end", 32'(m_write), 32'd0);
    check("wr_busy_end", 32'(busy), 32'd0);
    check("wr_no_a_rvalid", 32'(a_rvalid), 32'd0);
    check("wr_no_b_rvalid", 32'(b_rvalid), 32'd0);
    check("wr_addr_hold", 32'(m_addr), 32'h12345);

    // 3: B read 0x12345
    b_req = 1'b1; b_write = 1'b0; b_addr = 20'h12345;
    step();
    check("rd_b_ack", 32'(b_ack), 32'd1);
    check("rd_a_ack", 32'(a_ack), 32'd0);
    check("rd_m_write", 32'(m_write), 32'd0);
    b_req = 1'b0;
    step();
    check("rd_b_rvalid_early", 32'(b_rvalid), 32'd0);
    step();
    check("rd_b_rvalid", 32'(b_rvalid), 32'd1);
    check("rd_b_rdata", 32'(b_rdata), 32'hA5);
    check("rd_a_rvalid", 32'(a_rvalid), 32'd0);
    step();
    check("rd_b_rvalid_pulse", 32'(b_rvalid), 32'd0);
    check("rd_b_rdata_hold", 32'(b_rdata), 32'hA5);

    // 4: both held high from reset -> A,B,A,B every 3 cycles
    reset = 1'b1;
    a_req = 1'b1; a_write = 1'b0; a_addr = 20'h00011;
    b_req = 1'b1; b_write = 1'b0; b_addr = 20'h00022;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("rr_a_ack_k%0d", k), 32'(a_ack), 32'((k % 6) == 1));
      check($sformatf("rr_b_ack_k%0d", k), 32'(b_ack), 32'((k % 6) == 4));
      check($sformatf("rr_a_rvalid_k%0d", k), 32'(a_rvalid), 32'((k % 6) == 3));
      check($sformatf("rr_b_rvalid_k%0d", k), 32'(b_rvalid), 32'((k % 6) == 0));
      if ((k % 6) == 3) check($sformatf("rr_a_rdata_k%0d", k), 32'(a_rdata), 32'h3C);
      if ((k % 6) == 0) check($sformatf("rr_b_rdata_k%0d", k), 32'(b_rdata), 32'hC3);
    end
    a_req = 1'b0; b_req = 1'b0;

    // 5: B arrives during A's access and waits for the next IDLE
    a_req = 1'b1;
    step();
    check("wait_a_ack", 32'(a_ack), 32'd1);
    a_req = 1'b0; b_req = 1'b1;
    step();
    check("wait_b_ack_e1", 32'(b_ack), 32'd0);
    check("wait_busy_e1", 32'(busy), 32'd1);
    step();
    check("wait_b_ack_e2", 32'(b_ack), 32'd0);
    check("wait_a_rvalid", 32'(a_rvalid), 32'd1);
    check("wait_a_rdata", 32'(a_rdata), 32'h3C);
    step();
    check("wait_b_ack", 32'(b_ack), 32'd1);
    b_req = 1'b0;
    step();
    step();
    check("wait_b_rvalid", 32'(b_rvalid), 32'd1);
    check("wait_b_rdata", 32'(b_rdata), 32'hC3);

    // 6: reset in the first cycle of an A write aborts it
    a_req = 1'b1; a_write = 1'b1; a_addr = 20'h00100; a_wdata = 8'h77;
    step();
    check("abort_a_ack", 32'(a_ack), 32'd1);
    check("abort_m_write_on", 32'(m_write), 32'd1);
    reset = 1'b1; a_req = 1'b0;
    step();
    check("abort_m_write", 32'(m_write), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_a_rvalid", 32'(a_rvalid), 32'd0);
    check("abort_m_addr", 32'(m_addr), 32'd0);
    reset = 1'b0;
    a_req = 1'b1; a_write = 1'b0; a_addr = 20'h00011;
    b_req = 1'b1; b_write = 1'b0; b_addr = 20'h00022;
    step();
    check("abort_tie_a_ack", 32'(a_ack), 32'd1);
    check("abort_tie_b_ack", 32'(b_ack), 32'd0);
    a_req = 1'b0; b_req = 1'b0;
    step();
    step();
    check("abort_next_a_rvalid", 32'(a_rvalid), 32'd1);
    check("abort_next_a_rdata", 32'(a_rdata), 32'h3C);
    check("abort_next_b_rvalid", 32'(b_rvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
